// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: control inputs, memory-controller handshake and
// decoder-side instruction hand-off, grouped for the instruction_fetch_unit.
interface instruction_fetch_unit_if;
    logic        FetchEnable;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] InstructionBus;
    logic        ValidMemoryData;
    logic        InstructionAccept;
    logic [31:0] PCAddressBus;
    logic        PCGetNewInstruction;
    logic [31:0] InstructionRegister;
    logic        InstructionValid;
    logic [31:0] CurrentPC;
    logic        FetchError;

    // Fetch unit side: drives the fetch request and the latched instruction.
    modport master (
        input  FetchEnable, BranchTaken, BranchTarget,
        input  InstructionBus, ValidMemoryData, InstructionAccept,
        output PCAddressBus, PCGetNewInstruction,
        output InstructionRegister, InstructionValid, CurrentPC, FetchError
    );

    // Environment side: control unit, memory controller and decoder.
    modport slave (
        output FetchEnable, BranchTaken, BranchTarget,
        output InstructionBus, ValidMemoryData, InstructionAccept,
        input  PCAddressBus, PCGetNewInstruction,
        input  InstructionRegister, InstructionValid, CurrentPC, FetchError
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: IDLE/WAIT/HOLD sequencer that requests one word at
// the PC, latches it for the decoder and handles branch redirects, including
// redirects that arrive while a request is outstanding.
// Optional macro FETCH_TIMEOUT_EN adds a WAIT-state watchdog that pulses
// FetchError and abandons the request after FETCH_TIMEOUT cycles.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 64
) (
    input logic                       clk,
    input logic                       rst,
    instruction_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } state_t;

    if (FETCH_TIMEOUT < 1) begin : gTimeoutRange
        $error("FETCH_TIMEOUT must be at least 1");
    end

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic        req_r, req_s;
    logic [31:0] instr_r, instr_s;
    logic        instrValid_r, instrValid_s;
    logic [31:0] currentPc_r, currentPc_s;
    logic        fetchError_r, fetchError_s;
    logic        pendValid_r, pendValid_s;
    logic [31:0] pendTarget_r, pendTarget_s;
    logic [31:0] alignedTarget_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int             CNT_W        = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FETCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
    logic [CNT_W-1:0] waitCount_r, waitCount_s;
`endif

    // Branch targets are always word aligned.
    assign alignedTarget_s = {bus.BranchTarget[31:2], 2'b00};

    // Next-state and next-register computation for the fetch sequencer.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        req_s        = req_r;
        instr_s      = instr_r;
        instrValid_s = instrValid_r;
        currentPc_s  = currentPc_r;
        pendValid_s  = pendValid_r;
        pendTarget_s = pendTarget_r;
        fetchError_s = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        waitCount_s  = waitCount_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.BranchTaken) begin
                    pc_s         = alignedTarget_s;
                    instrValid_s = 1'b0;
                end else if (bus.FetchEnable) begin
                    state_s = WAIT;
                    req_s   = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    waitCount_s = {CNT_W{1'b0}};
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (bus.ValidMemoryData) begin
                    req_s       = 1'b0;
                    pendValid_s = 1'b0;
                    if (bus.BranchTaken) begin
                        // Same-edge redirect: the returned word is stale.
                        pc_s    = alignedTarget_s;
                        state_s = IDLE;
                    end else if (pendValid_r) begin
                        pc_s    = pendTarget_r;
                        state_s = IDLE;
                    end else begin
                        instr_s      = bus.InstructionBus;
                        currentPc_s  = pc_r;
                        pc_s         = pc_r + 32'd4;
                        instrValid_s = 1'b1;
                        state_s      = HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                end else if (waitCount_r == TIMEOUT_LAST) begin
                    // Watchdog expiry: drop the request, keep the PC unless a
                    // redirect is waiting to be applied.
                    fetchError_s = 1'b1;
                    req_s        = 1'b0;
                    pendValid_s  = 1'b0;
                    state_s      = IDLE;
                    if (bus.BranchTaken) begin
                        pc_s = alignedTarget_s;
                    end else if (pendValid_r) begin
                        pc_s = pendTarget_r;
                    end else begin
                        pc_s = pc_r;
                    end
                end else begin
                    waitCount_s = waitCount_r + CNT_ONE;
                    if (bus.BranchTaken) begin
                        pendValid_s  = 1'b1;
                        pendTarget_s = alignedTarget_s;
                    end else begin
                        pendValid_s = pendValid_r;
                    end
                end
`else
                end else if (bus.BranchTaken) begin
                    // Later redirects overwrite an earlier pending one.
                    pendValid_s  = 1'b1;
                    pendTarget_s = alignedTarget_s;
                end else begin
                    pendValid_s = pendValid_r;
                end
`endif
            end
            HOLD: begin
                if (bus.BranchTaken) begin
                    pc_s         = alignedTarget_s;
                    instrValid_s = 1'b0;
                    state_s      = IDLE;
                end else if (bus.InstructionAccept) begin
                    instrValid_s = 1'b0;
                    if (bus.FetchEnable) begin
                        state_s = WAIT;
                        req_s   = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        waitCount_s = {CNT_W{1'b0}};
`endif
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s      = IDLE;
                req_s        = 1'b0;
                instrValid_s = 1'b0;
                pendValid_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            pc_r         <= RESET_VECTOR;
            req_r        <= 1'b0;
            instr_r      <= 32'h0000_0000;
            instrValid_r <= 1'b0;
            currentPc_r  <= RESET_VECTOR;
            fetchError_r <= 1'b0;
            pendValid_r  <= 1'b0;
            pendTarget_r <= 32'h0000_0000;
`ifdef FETCH_TIMEOUT_EN
            waitCount_r  <= {CNT_W{1'b0}};
`endif
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            req_r        <= req_s;
            instr_r      <= instr_s;
            instrValid_r <= instrValid_s;
            currentPc_r  <= currentPc_s;
            fetchError_r <= fetchError_s;
            pendValid_r  <= pendValid_s;
            pendTarget_r <= pendTarget_s;
`ifdef FETCH_TIMEOUT_EN
            waitCount_r  <= waitCount_s;
`endif
        end
    end

    assign bus.PCAddressBus        = pc_r;
    assign bus.PCGetNewInstruction = req_r;
    assign bus.InstructionRegister = instr_r;
    assign bus.InstructionValid    = instrValid_r;
    assign bus.CurrentPC           = currentPc_r;
    assign bus.FetchError          = fetchError_r;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter FETCH_TIMEOUT, default 64, WAIT-state cycle limit when the timeout feature is compiled in.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port FetchEnable  input  1  control unit permits fetching.
REQ-006 SHALL have port BranchTaken  input  1  one-cycle redirect strobe.
REQ-007 SHALL have port BranchTarget  input  32  redirect address.
REQ-008 SHALL have port InstructionBus  input  32  instruction word from memory controller.
REQ-009 SHALL have port ValidMemoryData  input  1  memory controller data-valid.
REQ-010 SHALL have port InstructionAccept  input  1  decoder consumes held instruction.
REQ-011 SHALL have port PCAddressBus  output  32  fetch address to memory controller.
REQ-012 SHALL have port PCGetNewInstruction  output  1  fetch request, registered.
REQ-013 SHALL have port InstructionRegister  output  32  latched instruction.
REQ-014 SHALL have port InstructionValid  output  1  InstructionRegister holds an unconsumed instruction.
REQ-015 SHALL have port CurrentPC  output  32  address of the instruction in InstructionRegister.
REQ-016 SHALL have port FetchError  output  1  one-cycle timeout pulse.

Function
REQ-017 SHALL implement states IDLE, WAIT, HOLD; PCAddressBus SHALL always equal the internal PC.
REQ-018 IDLE: PCGetNewInstruction=0; FetchEnable=1 at an edge -> WAIT, PCGetNewInstruction=1 from that edge.
REQ-019 WAIT: PCGetNewInstruction and PCAddressBus SHALL stay stable until ValidMemoryData=1 is sampled; FetchEnable=0 SHALL NOT abort WAIT.
REQ-020 WAIT with ValidMemoryData=1, no pending redirect: same edge capture InstructionBus into InstructionRegister, CurrentPC<=PC, PC<=PC+4, InstructionValid<=1, PCGetNewInstruction<=0, -> HOLD (latency 0 cycles after valid).
REQ-021 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-022 HOLD: InstructionRegister, CurrentPC, InstructionValid stable until InstructionAccept=1; on accept InstructionValid<=0 and -> WAIT (request re-asserted) if FetchEnable=1, else IDLE.
REQ-023 PCGetNewInstruction SHALL be low for at least one full cycle between consecutive requests.
REQ-024 BranchTaken in IDLE or HOLD: PC<={BranchTarget[31:2],2'b00}, InstructionValid<=0, -> IDLE; BranchTaken SHALL win over simultaneous InstructionAccept.
REQ-025 BranchTaken in WAIT: store aligned target as pending redirect; request continues; on ValidMemoryData the word SHALL be discarded (InstructionValid stays 0), PC<=pending target, -> IDLE.
REQ-026 A second BranchTaken while a redirect is pending SHALL overwrite the pending target.
REQ-027 BranchTaken on the same edge as ValidMemoryData in WAIT SHALL discard the word and redirect.

Reset
REQ-028 rst=0 SHALL immediately force: state IDLE, PC=RESET_VECTOR, PCGetNewInstruction=0, InstructionRegister=0, InstructionValid=0, CurrentPC=RESET_VECTOR, FetchError=0, pending redirect cleared, timeout counter 0.
REQ-029 Reset mid-WAIT SHALL drop the request without waiting for ValidMemoryData.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN defined: WAIT counter counts cycles; on reaching FETCH_TIMEOUT without ValidMemoryData, FetchError pulses 1 cycle, PCGetNewInstruction<=0, PC unchanged (pending redirect applied if present), -> IDLE; counter clears on WAIT entry.
REQ-031 Macro FETCH_TIMEOUT_EN undefined: no counter logic; WAIT unbounded; FetchError tied 0.

Verification
REQ-032 Reset, FetchEnable=1, ValidMemoryData after 6 cycles with InstructionBus=339 -> PCAddressBus=0 during request, InstructionRegister=339, CurrentPC=0, PC=4, request low next cycle.
REQ-033 RESET_VECTOR=540, three fetches with immediate InstructionAccept -> addresses 540, 544, 548; request low >=1 cycle between each.
REQ-034 BranchTaken with BranchTarget=32'h0000_1177 during WAIT -> returned word discarded, next request at 32'h0000_1174.
REQ-035 PC=32'hFFFF_FFFC fetch completes -> PCAddressBus=0 for next request.
REQ-036 With FETCH_TIMEOUT_EN, FETCH_TIMEOUT=8, ValidMemoryData held 0 -> FetchError pulse at 8th WAIT cycle, retry at same address; without macro, request held indefinitely.
REQ-037 rst=0 asserted mid-WAIT and mid-HOLD -> all outputs at reset values asynchronously, before next clock edge.
